// File: rtl/irq_pkg.sv
// Shared constants and the priority encoder for the interrupt conditioner.
package irq_pkg;

    localparam int IRQ_ID_W  = 2;
    localparam int N_IRQ_MAX = 4;

    // Returns the highest set index of the masked pending vector, 0 when none is set.
    function automatic logic [IRQ_ID_W-1:0] irq_prio_enc(input logic [N_IRQ_MAX-1:0] req_vec);
        logic [IRQ_ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < N_IRQ_MAX; i++) begin
            if (req_vec[i]) begin
                id = IRQ_ID_W'(i);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/irq_conditioner_if.sv
// Pin/CPU side bundle of the interrupt conditioner.
//
// Handshake: irq_req is a level that stays high while any enabled line is
// pending; irq_id is valid whenever irq_req is high. The CPU answers with
// irq_ack high for exactly one cycle together with irq_ack_id; there is no
// ready signal because the conditioner accepts an ack on every cycle.
// irq_stable exposes the debounced line levels for observation.
interface irq_conditioner_if #(
    parameter int N_IRQ = 3
);
    import irq_pkg::*;

    logic [N_IRQ-1:0]    irq_raw;
    logic [N_IRQ-1:0]    irq_en;
    logic                irq_ack;
    logic [IRQ_ID_W-1:0] irq_ack_id;
    logic                irq_req;
    logic [IRQ_ID_W-1:0] irq_id;
    logic [N_IRQ-1:0]    irq_pending;
    logic [N_IRQ-1:0]    irq_overrun;
    logic [N_IRQ-1:0]    irq_stable;

    modport master (
        output irq_raw, irq_en, irq_ack, irq_ack_id,
        input  irq_req, irq_id, irq_pending, irq_overrun, irq_stable
    );

    modport slave (
        input  irq_raw, irq_en, irq_ack, irq_ack_id,
        output irq_req, irq_id, irq_pending, irq_overrun, irq_stable
    );

endinterface

// File: rtl/irq_debounce.sv
// One interrupt line: two-flop synchroniser, stable-sample counter and the
// accepted (debounced) level, plus a pulse on the accepted 0->1 change.
module irq_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: shift the synchroniser, count samples that disagree with the
    // accepted level and accept the new level on the last one of a full run.
    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset discards any partial count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign rise   = stable_d & ~stable_q;

endmodule

// File: rtl/irq_conditioner.sv
// Interrupt conditioner top: per-line debounce, sticky pending/overrun bits,
// ack decode and highest-index-wins request encoding.
module irq_conditioner
    import irq_pkg::*;
#(
    parameter int N_IRQ           = 3,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input logic               clk,
    input logic               rst,
    irq_conditioner_if.slave  bus
);
    logic [N_IRQ-1:0]     rise;
    logic [N_IRQ-1:0]     stable;
    logic [N_IRQ-1:0]     pending_q, pending_d;
    logic [N_IRQ-1:0]     overrun_q, overrun_d;
    logic [N_IRQ-1:0]     ack_match;
    logic [N_IRQ_MAX-1:0] masked_ext;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_line
        irq_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .raw   (bus.irq_raw[g]),
            .stable(stable[g]),
            .rise  (rise[g])
        );
    end

    // Pending/overrun next-state: a new edge always beats a same-cycle ack,
    // and an ID outside the implemented lines matches nothing.
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        ack_match = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            ack_match[i] = bus.irq_ack && (bus.irq_ack_id == IRQ_ID_W'(i));
            if (rise[i] && pending_q[i] && !ack_match[i]) begin
                overrun_d[i] = 1'b1;
            end else if (rise[i]) begin
                pending_d[i] = 1'b1;
            end else if (ack_match[i]) begin
                pending_d[i] = 1'b0;
                overrun_d[i] = 1'b0;
            end
        end
    end

    // Sticky pending and overrun registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // Request and ID derived from registered pending bits and the live enables.
    always_comb begin
        masked_ext           = '0;
        masked_ext[N_IRQ-1:0] = pending_q & bus.irq_en;
    end

    assign bus.irq_req     = |masked_ext;
    assign bus.irq_id      = irq_prio_enc(masked_ext);
    assign bus.irq_pending = pending_q;
    assign bus.irq_overrun = overrun_q;
    assign bus.irq_stable  = stable;

endmodule

// File: tb/tb_irq_conditioner.sv
// Bench for irq_conditioner: directed scenarios followed by random traffic,
// every cycle compared against a sample-history reference model.
module tb_irq_conditioner;
    import irq_pkg::*;

    localparam int N  = 3;
    localparam int DC = 4;

    // Clock and reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    irq_conditioner_if #(.N_IRQ(N)) bus ();

    irq_conditioner #(
        .N_IRQ(N),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: raw samples per edge; sync2 at an edge is the raw value
    // sampled two edges earlier, and the accepted level flips once the last DC
    // sync2 samples all disagree with it.
    logic [N-1:0] raw_hist[$];
    logic [N-1:0] m_stable;
    logic [N-1:0] m_pending;
    logic [N-1:0] m_overrun;

    task automatic model_edge();
        logic [N-1:0] rise_v;
        logic         all_diff;
        logic         v;
        int           idx;
        bit           ackm;
        if (rst) begin
            raw_hist.delete();
            m_stable  = '0;
            m_pending = '0;
            m_overrun = '0;
        end else begin
            raw_hist.push_back(bus.irq_raw);
            if (raw_hist.size() > DC + 2) void'(raw_hist.pop_front());
            rise_v = '0;
            for (int i = 0; i < N; i++) begin
                all_diff = 1'b1;
                for (int k = 0; k < DC; k++) begin
                    idx = raw_hist.size() - 3 - k;
                    v   = (idx >= 0) ? raw_hist[idx][i] : 1'b0;
                    if (v == m_stable[i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    if (!m_stable[i]) rise_v[i] = 1'b1;
                    m_stable[i] = ~m_stable[i];
                end
            end
            for (int i = 0; i < N; i++) begin
                ackm = bus.irq_ack && (int'(bus.irq_ack_id) == i);
                if (rise_v[i]) begin
                    if (m_pending[i] && !ackm) m_overrun[i] = 1'b1;
                    m_pending[i] = 1'b1;
                end else if (ackm) begin
                    m_pending[i] = 1'b0;
                    m_overrun[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [N-1:0] en_p;
        logic         exp_req;
        logic [1:0]   exp_id;
        en_p    = m_pending & bus.irq_en;
        exp_req = |en_p;
        exp_id  = 2'd0;
        for (int i = 0; i < N; i++) if (en_p[i]) exp_id = 2'(i);
        chk("pending", 8'(bus.irq_pending), 8'(m_pending));
        chk("overrun", 8'(bus.irq_overrun), 8'(m_overrun));
        chk("stable",  8'(bus.irq_stable),  8'(m_stable));
        chk("req",     8'(bus.irq_req),     8'(exp_req));
        chk("id",      8'(bus.irq_id),      8'(exp_id));
    endtask

    // Driver: one clock edge, model follows the same edge, outputs checked #1 later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic ack(input logic [1:0] id);
        bus.irq_ack    = 1'b1;
        bus.irq_ack_id = id;
        step();
        bus.irq_ack    = 1'b0;
        bus.irq_ack_id = 2'd0;
    endtask

    int hold[N];

    initial begin
        rst            = 1'b1;
        bus.irq_raw    = '0;
        bus.irq_en     = 3'b111;
        bus.irq_ack    = 1'b0;
        bus.irq_ack_id = 2'd0;
        m_stable       = '0;
        m_pending      = '0;
        m_overrun      = '0;

        // Reset and clean press on line 0
        steps(3);
        chk("rst_pending", 8'(bus.irq_pending), 8'h00);
        chk("rst_req", 8'(bus.irq_req), 8'h00);
        rst = 1'b0;
        steps(2);
        bus.irq_raw[0] = 1'b1;
        steps(DC + 1);
        chk("press_early", 8'(bus.irq_pending), 8'h00);
        step();
        chk("press_set", 8'(bus.irq_pending), 8'h01);
        chk("press_req", 8'(bus.irq_req), 8'h01);
        chk("press_id", 8'(bus.irq_id), 8'h00);

        // Bounce on line 1, then held
        bus.irq_raw[1] = 1'b1; step();
        bus.irq_raw[1] = 1'b0; step();
        bus.irq_raw[1] = 1'b1; step();
        bus.irq_raw[1] = 1'b0; step();
        chk("bounce_none", 8'(bus.irq_pending), 8'h01);
        bus.irq_raw[1] = 1'b1;
        steps(DC + 1);
        chk("bounce_early", 8'(bus.irq_pending), 8'h01);
        step();
        chk("bounce_set", 8'(bus.irq_pending), 8'h03);

        // Priority and back-to-back acks
        bus.irq_raw[2] = 1'b1;
        steps(DC + 2);
        chk("prio_id2", 8'(bus.irq_id), 8'h02);
        ack(2'd1);
        chk("ack1_pending", 8'(bus.irq_pending), 8'h05);
        ack(2'd2);
        chk("ack2_id", 8'(bus.irq_id), 8'h00);
        ack(2'd0);
        chk("ack0_req", 8'(bus.irq_req), 8'h00);

        // Overrun on line 1
        bus.irq_raw[1] = 1'b0; steps(DC + 2);
        bus.irq_raw[1] = 1'b1; steps(DC + 2);
        chk("ovr_first", 8'(bus.irq_pending), 8'h02);
        bus.irq_raw[1] = 1'b0; steps(DC + 2);
        bus.irq_raw[1] = 1'b1; steps(DC + 2);
        chk("ovr_flag", 8'(bus.irq_overrun), 8'h02);
        chk("ovr_pending", 8'(bus.irq_pending), 8'h02);
        ack(2'd1);
        chk("ovr_clear", 8'(bus.irq_overrun), 8'h00);
        chk("ovr_pclear", 8'(bus.irq_pending), 8'h00);

        // Ack colliding with a new edge on pending line 0
        bus.irq_raw[0] = 1'b0; steps(DC + 2);
        bus.irq_raw[0] = 1'b1; steps(DC + 2);
        bus.irq_raw[0] = 1'b0; steps(DC + 2);
        bus.irq_raw[0] = 1'b1; steps(DC + 1);
        ack(2'd0);
        chk("coll_pending", 8'(bus.irq_pending), 8'h01);
        chk("coll_overrun", 8'(bus.irq_overrun), 8'h00);
        ack(2'd3);
        chk("ack3_nochange", 8'(bus.irq_pending), 8'h01);

        // Masked pending line
        bus.irq_raw[2] = 1'b0; steps(DC + 2);
        bus.irq_raw[2] = 1'b1; steps(DC + 2);
        ack(2'd0);
        bus.irq_en = 3'b011;
        step();
        chk("mask_req", 8'(bus.irq_req), 8'h00);
        chk("mask_pending", 8'(bus.irq_pending), 8'h04);
        bus.irq_en = 3'b111;

        // Reset in the middle of a debounce run on line 1
        bus.irq_raw[1] = 1'b0; steps(DC + 2);
        ack(2'd2);
        bus.irq_raw[1] = 1'b1;
        steps(4);
        rst = 1'b1; step();
        rst = 1'b0;
        chk("midrst_clear", 8'(bus.irq_pending), 8'h00);
        steps(DC + 1);
        chk("midrst_early", 8'(bus.irq_pending[1]), 8'h00);
        step();
        chk("midrst_set", 8'(bus.irq_pending[1]), 8'h01);

        // Random traffic
        for (int i = 0; i < N; i++) hold[i] = 1;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    bus.irq_raw[i] = ~bus.irq_raw[i];
                    hold[i] = $urandom_range(1, 8);
                end
            end
            if ($urandom_range(0, 15) == 0) bus.irq_en = 3'($urandom_range(0, 7));
            bus.irq_ack    = ($urandom_range(0, 3) == 0);
            bus.irq_ack_id = 2'($urandom_range(0, 3));
            rst            = ($urandom_range(0, 199) == 0);
            step();
        end
        bus.irq_ack = 1'b0;
        rst         = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
